// File: rtl/master_fsm.sv
// master_fsm: byte-stream requester. Buffers producer bytes in a small FIFO
// and sends each one to a four-phase req/ack slave, counting completed
// transfers and flagging handshakes that time out.
module master_fsm #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [7:0]               in_data,
  output logic                     in_ready,
  output logic                     req,
  output logic [7:0]               data_out,
  input  logic                     ack,
  input  logic                     clr_err,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic [CNT_W-1:0]         tx_count,
  output logic                     timeout_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [AW-1:0]    wr_ptr_reg, wr_ptr_next;
  logic [AW-1:0]    rd_ptr_reg, rd_ptr_next;
  logic [AW:0]      count_reg, count_next;
  logic [TW-1:0]    tout_reg, tout_next;
  logic [CNT_W-1:0] tx_reg, tx_next;
  logic             err_reg, err_next;
  logic             req_reg, req_next;
  logic [7:0]       dout_reg;
  logic             push, pop;

  logic [7:0] mem [DEPTH];

  assign in_ready    = (count_reg < (AW+1)'(DEPTH));
  assign busy        = (state_reg != IDLE) || (count_reg != '0);
  assign req         = req_reg;
  assign data_out    = dout_reg;
  assign fifo_count  = count_reg;
  assign tx_count    = tx_reg;
  assign timeout_err = err_reg;

  // FIFO storage write port; contents need no reset since pointers gate reads.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= in_data;
  end

  // Registered read port: the head byte lands in data_out when IDLE pops it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)     dout_reg <= 8'h00;
    else if (pop) dout_reg <= mem[rd_ptr_reg];
  end

  // State and control register bank.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg  <= IDLE;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      tout_reg   <= '0;
      tx_reg     <= '0;
      err_reg    <= 1'b0;
      req_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
      tout_reg   <= tout_next;
      tx_reg     <= tx_next;
      err_reg    <= err_next;
      req_reg    <= req_next;
    end
  end

  // Next-state logic for the handshake FSM, FIFO pointers and counters.
  always_comb begin
    state_next  = state_reg;
    req_next    = req_reg;
    tout_next   = tout_reg;
    tx_next     = tx_reg;
    err_next    = err_reg;
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;

    push = in_valid && in_ready;
    // Only IDLE consumes the head; a byte written this edge is not yet visible.
    pop  = (state_reg == IDLE) && (count_reg != '0);

    // A clear is overridden below if a timeout lands on the same edge.
    if (clr_err) err_next = 1'b0;

    case (state_reg)
      IDLE: begin
        req_next = 1'b0;
        if (pop) begin
          req_next   = 1'b1;
          tout_next  = '0;
          state_next = REQ;
        end
      end
      REQ: begin
        req_next = 1'b1;
        if (ack) begin
          req_next   = 1'b0;
          tx_next    = tx_reg + CNT_W'(1);
          state_next = RELEASE;
        end else if (tout_reg == TW'(TIMEOUT - 1)) begin
          req_next   = 1'b0;
          err_next   = 1'b1;
          state_next = RELEASE;
        end else begin
          tout_next = tout_reg + TW'(1);
        end
      end
      RELEASE: begin
        // Wait out the slave's ack tail so it cannot re-latch a stale request.
        req_next = 1'b0;
        if (!ack) state_next = IDLE;
      end
      default: begin
        req_next   = 1'b0;
        state_next = IDLE;
      end
    endcase

    if (push) wr_ptr_next = wr_ptr_reg + AW'(1);
    if (pop)  rd_ptr_next = rd_ptr_reg + AW'(1);

    case ({push, pop})
      2'b10:   count_next = count_reg + (AW+1)'(1);
      2'b01:   count_next = count_reg - (AW+1)'(1);
      default: count_next = count_reg;
    endcase
  end

endmodule

// File: tb/tb_master_fsm.sv
// tb_master_fsm: directed vectors plus a behavioural four-phase slave for
// master_fsm (DEPTH=4, TIMEOUT=16, CNT_W=4).
module tb_master_fsm;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_ready;
  logic       req;
  logic [7:0] data_out;
  logic       ack = 1'b0;
  logic       clr_err = 1'b0;
  logic       busy;
  logic [2:0] fifo_count;
  logic [3:0] tx_count;
  logic       timeout_err;

  int nvec = 0;
  int nerr = 0;

  master_fsm #(.DEPTH(4), .TIMEOUT(16), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .req(req), .data_out(data_out), .ack(ack),
    .clr_err(clr_err), .busy(busy), .fifo_count(fifo_count),
    .tx_count(tx_count), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    nvec++;
    if (act !== want) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, want);
    end else begin
      $display("ok   %s: %0h", nm, act);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int bound, input string nm);
    int n;
    n = 0;
    while (busy && n < bound) begin
      tick();
      n++;
    end
    chk(nm, {31'd0, busy}, 0);
  endtask

  // Slave model: samples req, raises ack two edges later for two cycles.
  logic       slave_en = 1'b0;
  int         s_st = 0;
  logic [7:0] last_byte = 8'h00;
  logic [7:0] got_q[$];

  always @(posedge clk) begin
    if (!rst || !slave_en) begin
      s_st <= 0;
      ack  <= 1'b0;
    end else begin
      case (s_st)
        0: if (req) begin
             last_byte <= data_out;
             got_q.push_back(data_out);
             s_st <= 1;
           end
        1: s_st <= 2;
        2: begin ack <= 1'b1; s_st <= 3; end
        3: s_st <= 4;
        4: begin ack <= 1'b0; s_st <= 0; end
        default: s_st <= 0;
      endcase
    end
  end

  // Handshake protocol monitor: stable data, req falls only on ack, never rises into ack.
  logic       mon_en = 1'b0;
  logic       p_req = 1'b0, p_ack = 1'b0;
  logic [7:0] p_dout = 8'h00;

  always @(negedge clk) begin
    if (mon_en) begin
      if (p_req && req)  chk("dout_stable", {24'd0, data_out}, {24'd0, p_dout});
      if (p_req && !req) chk("req_fall_on_ack", {31'd0, p_ack}, 1);
      if (!p_req && req) chk("req_rise_ack_low", {30'd0, p_ack, ack}, 0);
    end
    p_req  = req;
    p_ack  = ack;
    p_dout = data_out;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic       vld;
    logic [7:0] din;
    logic       e_req;
    logic [7:0] e_dout;
    logic [2:0] e_cnt;
    logic       e_rdy;
    logic       e_busy;
  } vec_t;

  vec_t tbl[7];

  initial begin
    int hi, n;
    logic acc;

    // Stalled-slave fill: 1 byte in flight plus 4 buffered, then full.
    tbl[0] = '{1'b1, 8'h01, 1'b0, 8'h00, 3'd1, 1'b1, 1'b1};
    tbl[1] = '{1'b1, 8'h02, 1'b1, 8'h01, 3'd1, 1'b1, 1'b1}; // push+pop same edge
    tbl[2] = '{1'b1, 8'h03, 1'b1, 8'h01, 3'd2, 1'b1, 1'b1};
    tbl[3] = '{1'b1, 8'h04, 1'b1, 8'h01, 3'd3, 1'b1, 1'b1};
    tbl[4] = '{1'b1, 8'h05, 1'b1, 8'h01, 3'd4, 1'b0, 1'b1};
    tbl[5] = '{1'b1, 8'h06, 1'b1, 8'h01, 3'd4, 1'b0, 1'b1}; // valid while full
    tbl[6] = '{1'b0, 8'h00, 1'b1, 8'h01, 3'd4, 1'b0, 1'b1};

    // Reset and idle state
    repeat (3) tick();
    rst = 1'b1;
    chk("rst_req", {31'd0, req}, 0);
    chk("rst_dout", {24'd0, data_out}, 0);
    chk("rst_in_ready", {31'd0, in_ready}, 1);
    chk("rst_fifo_count", {29'd0, fifo_count}, 0);
    chk("rst_tx_count", {28'd0, tx_count}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_err", {31'd0, timeout_err}, 0);

    // Table: FIFO fill with ack held low
    for (int i = 0; i < 7; i++) begin
      in_valid = tbl[i].vld;
      in_data  = tbl[i].din;
      tick();
      chk($sformatf("vec%0d_req", i), {31'd0, req}, {31'd0, tbl[i].e_req});
      chk($sformatf("vec%0d_dout", i), {24'd0, data_out}, {24'd0, tbl[i].e_dout});
      chk($sformatf("vec%0d_count", i), {29'd0, fifo_count}, {29'd0, tbl[i].e_cnt});
      chk($sformatf("vec%0d_ready", i), {31'd0, in_ready}, {31'd0, tbl[i].e_rdy});
      chk($sformatf("vec%0d_busy", i), {31'd0, busy}, {31'd0, tbl[i].e_busy});
    end
    in_valid = 1'b0;

    // Asynchronous reset mid-REQ: req drops before the next edge
    #3 rst = 1'b0;
    #1;
    chk("async_rst_req", {31'd0, req}, 0);
    chk("async_rst_count", {29'd0, fifo_count}, 0);
    chk("async_rst_busy", {31'd0, busy}, 0);
    chk("async_rst_ready", {31'd0, in_ready}, 1);
    #2 rst = 1'b1;
    tick();
    chk("post_rst_count", {29'd0, fifo_count}, 0);
    chk("post_rst_req", {31'd0, req}, 0);

    // Timeout: 5C abandoned after exactly 16 req cycles, then 5D attempted
    in_valid = 1'b1; in_data = 8'h5C;
    tick();
    in_data = 8'h5D;
    tick();
    in_valid = 1'b0;
    chk("to_req_rise", {31'd0, req}, 1);
    chk("to_dout", {24'd0, data_out}, 32'h5C);
    hi = 1;
    while (req && hi < 40) begin
      tick();
      if (req) hi++;
    end
    chk("to_req_cycles", hi, 16);
    chk("to_err_set", {31'd0, timeout_err}, 1);
    chk("to_tx_unchanged", {28'd0, tx_count}, 0);
    n = 0;
    while (!req && n < 5) begin tick(); n++; end
    chk("to_next_req", {31'd0, req}, 1);
    chk("to_next_dout", {24'd0, data_out}, 32'h5D);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    chk("clr_err", {31'd0, timeout_err}, 0);
    repeat (14) tick();
    chk("to_req_last_cycle", {31'd0, req}, 1);
    clr_err = 1'b1;
    tick();
    chk("to2_req_fall", {31'd0, req}, 0);
    chk("set_wins_over_clr", {31'd0, timeout_err}, 1);
    tick();
    clr_err = 1'b0;
    chk("clr_err2", {31'd0, timeout_err}, 0);
    chk("to_tx_still0", {28'd0, tx_count}, 0);

    // Single byte with slave
    slave_en = 1'b1;
    mon_en   = 1'b1;
    got_q.delete();
    in_valid = 1'b1; in_data = 8'hA5;
    tick();
    in_valid = 1'b0;
    tick();
    chk("single_req", {31'd0, req}, 1);
    chk("single_dout", {24'd0, data_out}, 32'hA5);
    wait_idle(30, "single_idle");
    chk("single_nbytes", got_q.size(), 1);
    chk("single_last_byte", {24'd0, last_byte}, 32'hA5);
    chk("single_tx", {28'd0, tx_count}, 1);
    chk("single_req_low", {31'd0, req}, 0);

    // Back-to-back 11, 22, 33
    got_q.delete();
    in_valid = 1'b1;
    in_data = 8'h11; tick();
    in_data = 8'h22; tick();
    in_data = 8'h33; tick();
    in_valid = 1'b0;
    wait_idle(80, "b2b_idle");
    chk("b2b_nbytes", got_q.size(), 3);
    if (got_q.size() == 3) begin
      chk("b2b_byte0", {24'd0, got_q[0]}, 32'h11);
      chk("b2b_byte1", {24'd0, got_q[1]}, 32'h22);
      chk("b2b_byte2", {24'd0, got_q[2]}, 32'h33);
    end
    chk("b2b_tx", {28'd0, tx_count}, 4);

    // Wrap: 16 transfers from reset wrap tx_count to 0; then one more gives 1
    mon_en = 1'b0;
    #3 rst = 1'b0;
    #3 rst = 1'b1;
    tick();
    tick();
    mon_en = 1'b1;
    got_q.delete();
    for (int i = 0; i < 17; i++) begin
      in_valid = 1'b1;
      in_data  = 8'h40 + 8'(i);
      acc = 1'b0;
      n = 0;
      while (!acc && n < 200) begin
        acc = in_ready;
        tick();
        n++;
      end
      if (!acc) chk($sformatf("wrap_push%0d", i), {31'd0, acc}, 1);
      in_valid = 1'b0;
      if (i == 15) begin
        wait_idle(400, "wrap_idle");
        chk("wrap_tx_zero", {28'd0, tx_count}, 0);
      end
    end
    wait_idle(60, "wrap_idle2");
    chk("wrap_tx_one", {28'd0, tx_count}, 1);
    chk("wrap_nbytes", got_q.size(), 17);
    if (got_q.size() == 17) begin
      for (int i = 0; i < 17; i++)
        chk($sformatf("wrap_byte%0d", i), {24'd0, got_q[i]}, {24'd0, 8'h40 + 8'(i)});
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/master_fsm.md
Name: master_fsm

Overview:
Byte-stream requester that sits directly upstream of the slave_fsm four-phase req/ack responder. It accepts bytes from a producer over a valid/ready interface and buffers them in a small FIFO. It presents one byte at a time on data_out with req, and completes a full four-phase handshake per byte: req high until ack high, then req low until ack low. It also counts completed transfers and flags handshake timeouts.

Parameters:
DEPTH, 4, FIFO depth in bytes; power of two, minimum 2.
TIMEOUT, 16, max cycles req may stay high without ack before the byte is abandoned; minimum 4.
CNT_W, 16, width of tx_count.

Ports:
clk  in  1  clock; all state updates on rising edge.
rst  in  1  asynchronous, active-low reset (rst=0 resets immediately, independent of clk).
in_valid  in  1  producer has a byte on in_data.
in_data  in  8  producer byte.
in_ready  out  1  FIFO can accept; a push happens when in_valid & in_ready at a clock edge.
req  out  1  request to slave; registered.
data_out  out  8  byte under transfer; registered, stable for the whole time req=1.
ack  in  1  acknowledge from slave.
clr_err  in  1  synchronous clear of timeout_err.
busy  out  1  1 when state != IDLE or FIFO not empty.
fifo_count  out  $clog2(DEPTH)+1  bytes currently buffered.
tx_count  out  CNT_W  completed transfers; wraps modulo 2^CNT_W.
timeout_err  out  1  sticky timeout flag.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; req=0; data_out=8'h00; FIFO empty (both pointers 0, fifo_count=0).
  - tx_count=0; timeout_err=0; timeout counter=0.
  - in_ready=1 after release; busy=0.
- Reset mid-handshake drops req at once and discards all buffered bytes.
- FIFO:
  - Circular buffer; read/write pointers wrap at DEPTH.
  - in_ready = (fifo_count < DEPTH). No same-cycle bypass: a byte pushed at edge N is poppable at edge N+1 at the earliest.
  - Push and pop at the same edge leaves fifo_count unchanged.
  - A push while full cannot occur, because in_ready=0.
- State machine, evaluated at each rising edge:
  - IDLE: if FIFO not empty, pop the head into data_out, set req=1, clear the timeout counter, go to REQ. Otherwise stay; req=0.
  - REQ: req=1, data_out held.
    - If ack=1: req<=0, tx_count<=tx_count+1, go to RELEASE.
    - Else if timeout counter = TIMEOUT-1: req<=0, timeout_err<=1, go to RELEASE. The byte is abandoned and tx_count is not incremented.
    - Else: increment the timeout counter.
  - RELEASE: req=0. If ack=0, go to IDLE; otherwise stay. This prevents the slave from re-latching while its ack tail is still high.
  - Unused encodings go to IDLE with req=0.
- Timing against slave_fsm:
  - The slave registers ack two edges after sampling req.
  - ack stays high two cycles.
  - A minimum transfer occupies 6 cycles from req rise to IDLE re-entry.
  - The next req rises one cycle after IDLE is re-entered, if the FIFO is non-empty.
- timeout_err:
  - Sticky until clr_err=1.
  - clr_err and a new timeout at the same edge leaves timeout_err=1 (set wins).
- data_out is only meaningful while req=1; it keeps its last value otherwise.

Test Plan:
- Reset/idle: hold rst=0, then release. Require req=0, data_out=00, in_ready=1, fifo_count=0, tx_count=0, busy=0. Assert rst=0 asynchronously mid-REQ; req must fall before the next clk edge.
- Single byte with a slave_fsm model: push 8'hA5 at edge 0. Require req=1 and data_out=A5 after edge 1. Require req to stay 1 until ack is sampled 1, then fall. Require no second req while ack is still 1. The slave's last_byte must be A5, then tx_count=1 and the FSM back in IDLE.
- Back-to-back: push 8'h11, 8'h22, 8'h33 on consecutive cycles. Require three handshakes in order, data_out stable during each req, slave last_byte sequence 11, 22, 33, tx_count=3, and no req rising while ack=1.
- FIFO full: with ack tied 0 (transfer stalled), push bytes until in_ready=0. Require 5 bytes accepted (1 in flight plus DEPTH=4), fifo_count=4, and in_valid with in_ready=0 leaving the FIFO unchanged. A simultaneous push and pop must keep fifo_count constant.
- Timeout: ack tied 0 and push 8'h5C. Require req high for exactly 16 cycles, then 0, with timeout_err=1 and tx_count unchanged; the next byte is then attempted. Then pulse clr_err; require timeout_err=0.
- Wrap: push and complete 2^CNT_W transfers (use CNT_W=4 for 16 transfers). Require tx_count to wrap to 0, and FIFO pointers to wrap repeatedly with byte order preserved.
